ssd_scan_mux: RTL and testbench

- Time-multiplexed scanner that sits directly upstream of the BCD seven-segment decoder.
- Holds NUM_DIGITS 4-bit digits and presents one digit per slot on binaryNumber, which drives the decoder input.
- Drives the matching active-low digit enable for a shared-segment display.
- Buffers host updates so a refresh frame never shows a mix of old and new digits.

---
 rtl/ssd_scan_mux.sv | 131 +++++++++++++
 tb/tb_ssd_scan_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed digit scanner feeding a BCD seven-segment decoder.
// Define GHOST_BLANK_EN to blank the first output cycle of every slot (anti-ghosting).
module ssd_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digitsIn,
    input  logic                    loadDigits,
    input  logic [NUM_DIGITS-1:0]   blankMask,
    output logic [3:0]              binaryNumber,
    output logic [NUM_DIGITS-1:0]   digitEnable,
    output logic                    frameTick
);
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       BLANK_CODE = 4'hF;

    logic [CNT_W-1:0]      refresh_cnt_q, refresh_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic                  wrap_q, wrap_d;
    logic [3:0]            binary_number_q, binary_number_d;
    logic [NUM_DIGITS-1:0] digit_enable_q, digit_enable_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [3:0]            digit_sel;
    logic [NUM_DIGITS-1:0] enable_sel;
    logic                  slot_blank;
    logic                  slot_dark;

    // Scan position: refresh counter inside a slot, digit index across slots.
    always_comb begin
        slot_end      = (refresh_cnt_q == CNT_MAX);
        frame_wrap    = slot_end && (digit_idx_q == IDX_MAX);
        refresh_cnt_d = slot_end ? '0 : refresh_cnt_q + 1'b1;
        digit_idx_d   = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == IDX_MAX) ? '0 : digit_idx_q + 1'b1;
        end
    end

    // Host updates are parked in pending and only promoted to shadow on the frame wrap,
    // so a frame never mixes old and new digits. A load on the wrap edge bypasses pending.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path
        // through the if/else leaves it unassigned, which would otherwise infer a latch.
        shadow_d        = shadow_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (frame_wrap) begin
            if (loadDigits) begin
                shadow_d = digitsIn;
            end else if (pending_valid_q) begin
                shadow_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (loadDigits) begin
            pending_d       = digitsIn;
            pending_valid_d = 1'b1;
        end
    end

    // Slot value for the digit index held before the edge; outputs lag the index by one cycle.
    always_comb begin
        digit_sel  = '0;
        enable_sel = '1;
        slot_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                digit_sel     = shadow_q[4*k +: 4];
                enable_sel[k] = 1'b0;
                slot_blank    = blankMask[k];
            end
        end
`ifdef GHOST_BLANK_EN
        slot_dark = slot_blank || (refresh_cnt_q == '0);
`else
        slot_dark = slot_blank;
`endif
        binary_number_d = slot_dark ? BLANK_CODE : digit_sel;
        digit_enable_d  = slot_dark ? '1 : enable_sel;
        wrap_d          = frame_wrap;
        frame_tick_d    = wrap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q   <= '0;
            digit_idx_q     <= '0;
            shadow_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            wrap_q          <= 1'b0;
            binary_number_q <= BLANK_CODE;
            digit_enable_q  <= '1;
            frame_tick_q    <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order inside the block.
            refresh_cnt_q   <= refresh_cnt_d;
            digit_idx_q     <= digit_idx_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            wrap_q          <= wrap_d;
            binary_number_q <= binary_number_d;
            digit_enable_q  <= digit_enable_d;
            frame_tick_q    <= frame_tick_d;
        end
    end

    assign binaryNumber = binary_number_q;
    assign digitEnable  = digit_enable_q;
    assign frameTick    = frame_tick_q;

    // A dark display always carries the blank code, and at most one digit is ever enabled.
    assert property (@(posedge clk) disable iff (reset) $onehot0(~digitEnable));
    assert property (@(posedge clk) disable iff (reset)
                     (digitEnable == '1) |-> (binaryNumber == BLANK_CODE));

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Testbench for ssd_scan_mux: vector table for reset/scan start, scoreboarded scan sequences,
// plus a second instance with REFRESH_DIV=1.
module tb_ssd_scan_mux;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;
    localparam int NVEC  = 22;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] en;
        logic       tick;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          ld;
        logic [15:0] din;
        logic [3:0]  mask;
        exp_t        want;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] digitsIn;
    logic        loadDigits;
    logic [3:0]  blankMask;
    logic [3:0]  binaryNumber;
    logic [3:0]  digitEnable;
    logic        frameTick;

    logic        rst1;
    logic [3:0]  bin1;
    logic [1:0]  en1;
    logic        tick1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[NVEC];
    logic [3:0] en_pat[4];

    // Reference state, tracked by counting non-reset edges since the last reset.
    int          n;
    logic [15:0] disp;
    logic [15:0] pend;
    bit          pv;

    ssd_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .digitsIn    (digitsIn),
        .loadDigits  (loadDigits),
        .blankMask   (blankMask),
        .binaryNumber(binaryNumber),
        .digitEnable (digitEnable),
        .frameTick   (frameTick)
    );

    ssd_scan_mux #(.NUM_DIGITS(2), .REFRESH_DIV(1)) u_dut_fast (
        .clk         (clk),
        .reset       (rst1),
        .digitsIn    (8'h00),
        .loadDigits  (1'b0),
        .blankMask   (2'b00),
        .binaryNumber(bin1),
        .digitEnable (en1),
        .frameTick   (tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic exp_t model_expect(input bit rst, input logic [3:0] mask);
        exp_t e;
        int   slot;
        bit   dark;
        if (rst) begin
            e.bin  = 4'hF;
            e.en   = 4'hF;
            e.tick = 1'b0;
            return e;
        end
        slot = (n / RD) % ND;
        dark = mask[slot];
`ifdef GHOST_BLANK_EN
        if ((n % RD) == 0) dark = 1'b1;
`endif
        e.bin  = dark ? 4'hF : disp[4*slot +: 4];
        e.en   = dark ? 4'hF : ~(4'b0001 << slot);
        e.tick = (n >= FRAME) && ((n % FRAME) == 0);
        return e;
    endfunction

    task automatic model_advance(input bit rst, input bit ld, input logic [15:0] din);
        if (rst) begin
            n    = 0;
            disp = '0;
            pend = '0;
            pv   = 1'b0;
        end else begin
            if ((n % FRAME) == FRAME - 1) begin
                if (ld) disp = din;
                else if (pv) disp = pend;
                pv = 1'b0;
            end else if (ld) begin
                pend = din;
                pv   = 1'b1;
            end
            n++;
        end
    endtask

    task automatic drive_edge(input bit rst, input bit ld, input logic [15:0] din,
                              input logic [3:0] mask, input exp_t want);
        reset      = rst;
        loadDigits = ld;
        digitsIn   = din;
        blankMask  = mask;
        sb.push_back(want);
        model_advance(rst, ld, din);
        @(posedge clk);
        #2;
    endtask

    task automatic step(input bit rst, input bit ld, input logic [15:0] din,
                        input logic [3:0] mask);
        drive_edge(rst, ld, din, mask, model_expect(rst, mask));
    endtask

    task automatic idle(input int cycles, input logic [3:0] mask);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0000, mask);
    endtask

    task automatic idle_until(input int pos);
        for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) step(1'b0, 1'b0, 16'h0000, 4'b0000);
    endtask

    // Scoreboard side: each edge's outputs are compared against the entry queued before it.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check($sformatf("binaryNumber@%0d", edge_cnt), 32'(binaryNumber), 32'(mon_e.bin));
            check($sformatf("digitEnable@%0d", edge_cnt), 32'(digitEnable), 32'(mon_e.en));
            check($sformatf("frameTick@%0d", edge_cnt), 32'(frameTick), 32'(mon_e.tick));
        end
    end

    initial begin
        reset      = 1'b1;
        loadDigits = 1'b0;
        digitsIn   = '0;
        blankMask  = '0;
        rst1       = 1'b1;
        n          = 0;
        disp       = '0;
        pend       = '0;
        pv         = 1'b0;

        en_pat[0] = 4'b1110;
        en_pat[1] = 4'b1101;
        en_pat[2] = 4'b1011;
        en_pat[3] = 4'b0111;

        // Three reset cycles, then the first frame and a bit: enables walk right to left, digits 0.
        for (int i = 0; i < NVEC; i++) begin
            bit dark;
            int k;
            vecs[i].rst  = (i < 3);
            vecs[i].ld   = 1'b0;
            vecs[i].din  = 16'h0000;
            vecs[i].mask = 4'b0000;
            if (i < 3) begin
                vecs[i].want.bin  = 4'hF;
                vecs[i].want.en   = 4'b1111;
                vecs[i].want.tick = 1'b0;
            end else begin
                k    = i - 3;
                dark = 1'b0;
`ifdef GHOST_BLANK_EN
                dark = ((k % 4) == 0);
`endif
                vecs[i].want.bin  = dark ? 4'hF : 4'h0;
                vecs[i].want.en   = dark ? 4'b1111 : en_pat[(k / 4) % 4];
                vecs[i].want.tick = (k == 16);
            end
        end

        for (int i = 0; i < NVEC; i++) begin
            drive_edge(vecs[i].rst, vecs[i].ld, vecs[i].din, vecs[i].mask, vecs[i].want);
        end

        // Load mid-slot 2: held until the wrap, then 1,2,3,4 across slots 0..3.
        idle_until(9);
        step(1'b0, 1'b1, 16'h4321, 4'b0000);
        idle(40, 4'b0000);

        // Two loads within one frame: the second one wins.
        idle_until(2);
        step(1'b0, 1'b1, 16'h1111, 4'b0000);
        idle(3, 4'b0000);
        step(1'b0, 1'b1, 16'h9876, 4'b0000);
        idle(34, 4'b0000);

        // Load on the wrap edge itself goes straight to the display at the next slot 0.
        idle_until(15);
        step(1'b0, 1'b1, 16'h5555, 4'b0000);
        idle(18, 4'b0000);

        // Blanking of slot 2 and the non-BCD value F in slot 3.
        idle_until(0);
        step(1'b0, 1'b1, 16'hF987, 4'b0000);
        idle(20, 4'b0000);
        idle(20, 4'b0100);

        // Reset in slot 2 with a load pending: the pending digits must never show.
        idle_until(5);
        step(1'b0, 1'b1, 16'h7777, 4'b0000);
        idle_until(9);
        step(1'b1, 1'b0, 16'h0000, 4'b0000);
        idle(40, 4'b0000);

        // REFRESH_DIV=1, two digits: reset state, then one slot per cycle.
        step(1'b0, 1'b0, 16'h0000, 4'b0000);
        check("fast_reset_en", 32'(en1), 32'(2'b11));
        check("fast_reset_bin", 32'(bin1), 32'(4'hF));
        check("fast_reset_tick", 32'(tick1), 32'(1'b0));
        rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] want_en;
            logic [3:0] want_bin;
            step(1'b0, 1'b0, 16'h0000, 4'b0000);
            want_en  = ((k % 2) == 0) ? 2'b10 : 2'b01;
            want_bin = 4'h0;
`ifdef GHOST_BLANK_EN
            want_en  = 2'b11;
            want_bin = 4'hF;
`endif
            check($sformatf("fast_en%0d", k), 32'(en1), 32'(want_en));
            check($sformatf("fast_bin%0d", k), 32'(bin1), 32'(want_bin));
            check($sformatf("fast_tick%0d", k), 32'(tick1), 32'((k >= 2) && ((k % 2) == 0)));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
